// File: rtl/sdram_pkg.sv
// Shared SDRAM command-bus definitions: command codes, A10 constant, arbiter FSM states
// and the command/bank/address payload carried on the SDRAM pins.
package sdram_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned OWED_W = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP     = 4'h0,
        CMD_ACT     = 4'h1,
        CMD_RD      = 4'h2,
        CMD_WR      = 4'h3,
        CMD_PRE_ALL = 4'h4,
        CMD_PRE_ONE = 4'h5,
        CMD_RDA     = 4'h6,
        CMD_WRA     = 4'h7,
        CMD_REF     = 4'h8
    } sdram_cmd_e;

    localparam logic [ADDR_W-1:0] ADDR_A10 = 11'h400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_PRE,
        ST_TRP,
        ST_REF,
        ST_TRFC,
        ST_DONE
    } arb_state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [BANK_W-1:0] bank;
        logic [ADDR_W-1:0] addr;
    } sdram_bus_t;

    function automatic sdram_bus_t bus_cmd(input logic [CMD_W-1:0]  cmd,
                                           input logic [BANK_W-1:0] bank,
                                           input logic [ADDR_W-1:0] addr);
        sdram_bus_t b;
        b.cmd  = cmd;
        b.bank = bank;
        b.addr = addr;
        return b;
    endfunction

endpackage

// File: rtl/refresh_tick_ctr.sv
// Refresh interval timer and owed-refresh accumulator with saturation and a sticky
// overflow flag (a tick was lost because the owed count was already full).
module refresh_tick_ctr
    import sdram_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = 780,
    parameter int unsigned REF_MAX      = 8
) (
    input  logic              sclk,
    input  logic              sresetn,
    input  logic              ref_dec,
    output logic [OWED_W-1:0] owed,
    output logic              ref_err
);

    localparam int unsigned       CNT_W      = $clog2(REF_INTERVAL + 1);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(REF_INTERVAL - 1);
    localparam logic [OWED_W-1:0] OWED_SAT   = OWED_W'(REF_MAX);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OWED_W-1:0] owed_q, owed_d;
    logic              err_q, err_d;
    logic              tick_c;

    always_comb begin
        tick_c = (cnt_q == '0);
        cnt_d  = tick_c ? CNT_RELOAD : cnt_q - CNT_W'(1);
        owed_d = owed_q;
        err_d  = err_q;
        // A tick coinciding with an issued REF cancels out and cannot overflow.
        if (tick_c && !ref_dec) begin
            if (owed_q == OWED_SAT) begin
                err_d = 1'b1;
            end else begin
                owed_d = owed_q + OWED_W'(1);
            end
        end else if (!tick_c && ref_dec && (owed_q != '0)) begin
            owed_d = owed_q - OWED_W'(1);
        end
    end

    always_ff @(posedge sclk or negedge sresetn) begin
        if (!sresetn) begin
            cnt_q  <= CNT_RELOAD;
            owed_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            owed_q <= owed_d;
            err_q  <= err_d;
        end
    end

    assign owed    = owed_q;
    assign ref_err = err_q;

endmodule

// File: rtl/sdram_refresh_arbiter.sv
// Shares the SDRAM command bus between the command generator and auto-refresh.
// Optional SDRAM_REF_POSTPONE_EN: defer refresh while the generator is busy until nearly full.
module sdram_refresh_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = 780,
    parameter int unsigned T_RP         = 3,
    parameter int unsigned T_RFC        = 7,
    parameter int unsigned REF_MAX      = 8
) (
    input  logic              sclk,
    input  logic              sresetn,
    input  logic              iGen_Req,
    input  logic [CMD_W-1:0]  iGen_Cmd,
    input  logic [BANK_W-1:0] iGen_Bank,
    input  logic [ADDR_W-1:0] iGen_Addr,
    input  logic              iGen_Idle,
    output logic              oGen_Gnt,
    output logic [CMD_W-1:0]  oCmd,
    output logic [BANK_W-1:0] oBank,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oRefBusy,
    output logic              oBanksClosed,
    output logic              oRefErr
);

    localparam int unsigned       WAIT_MAX  = (T_RFC > T_RP) ? T_RFC : T_RP;
    localparam int unsigned       WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] TRP_LOAD  = WAIT_W'(T_RP - 2);
    localparam logic [WAIT_W-1:0] TRFC_LOAD = WAIT_W'(T_RFC - 2);
    localparam logic [OWED_W-1:0] OWED_HIGH = OWED_W'(REF_MAX - 1);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    sdram_bus_t        bus_q, bus_d;
    logic              gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              closed_q, closed_d;
    logic [OWED_W-1:0] owed;
    logic              ref_dec_c;
    logic              refresh_due_c;

    refresh_tick_ctr #(
        .REF_INTERVAL (REF_INTERVAL),
        .REF_MAX      (REF_MAX)
    ) u_tick_ctr (
        .sclk    (sclk),
        .sresetn (sresetn),
        .ref_dec (ref_dec_c),
        .owed    (owed),
        .ref_err (oRefErr)
    );

    assign ref_dec_c = (state_q == ST_REF);

`ifdef SDRAM_REF_POSTPONE_EN
    assign refresh_due_c = (owed != '0) && (!iGen_Req || (owed >= OWED_HIGH));
`else
    assign refresh_due_c = (owed != '0);
`endif

    // Outputs are registered copies of what the next state drives on the bus.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        bus_d    = bus_cmd(CMD_NOP, '0, '0);
        gnt_d    = 1'b0;
        busy_d   = 1'b0;
        closed_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (refresh_due_c) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (iGen_Idle) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                state_d = ST_TRP;
                wait_d  = TRP_LOAD;
            end
            ST_TRP: begin
                if (wait_q == '0) begin
                    state_d = ST_REF;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_REF: begin
                state_d = ST_TRFC;
                wait_d  = TRFC_LOAD;
            end
            ST_TRFC: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else if (owed != '0) begin
                    state_d = ST_REF;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A command sampled in the final IDLE cycle still reaches the pins.
        if ((state_q == ST_IDLE) && gnt_q && iGen_Req) begin
            bus_d = bus_cmd(iGen_Cmd, iGen_Bank, iGen_Addr);
        end else if (state_d == ST_PRE) begin
            bus_d = bus_cmd(CMD_PRE_ALL, '0, ADDR_A10);
        end else if (state_d == ST_REF) begin
            bus_d = bus_cmd(CMD_REF, '0, '0);
        end

        gnt_d    = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
        closed_d = (state_d == ST_DONE);
    end

    always_ff @(posedge sclk or negedge sresetn) begin
        if (!sresetn) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            bus_q    <= '0;
            gnt_q    <= 1'b0;
            busy_q   <= 1'b0;
            closed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            bus_q    <= bus_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            closed_q <= closed_d;
        end
    end

    assign oGen_Gnt     = gnt_q;
    assign oCmd         = bus_q.cmd;
    assign oBank        = bus_q.bank;
    assign oAddr        = bus_q.addr;
    assign oRefBusy     = busy_q;
    assign oBanksClosed = closed_q;

endmodule

// File: tb/tb_sdram_refresh_arbiter.sv
// Directed bench for sdram_refresh_arbiter with REF_INTERVAL=20, T_RP=3, T_RFC=7.
// Cycle numbers below count rising edges since the latest reset release.
module tb_sdram_refresh_arbiter;

    localparam int REF_INTERVAL = 20;
    localparam int T_RP         = 3;
    localparam int T_RFC        = 7;
    localparam int REF_MAX      = 8;

    localparam logic [3:0] C_NOP = 4'h0;
    localparam logic [3:0] C_ACT = 4'h1;
    localparam logic [3:0] C_RD  = 4'h2;
    localparam logic [3:0] C_PRA = 4'h4;
    localparam logic [3:0] C_REF = 4'h8;

    logic        sclk = 1'b0;
    logic        sresetn;
    logic        gen_req;
    logic [3:0]  gen_cmd;
    logic [1:0]  gen_bank;
    logic [10:0] gen_addr;
    logic        gen_idle;
    logic        gen_gnt;
    logic [3:0]  cmd;
    logic [1:0]  bank;
    logic [10:0] addr;
    logic        ref_busy;
    logic        banks_closed;
    logic        ref_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 sclk = ~sclk;

    sdram_refresh_arbiter #(
        .REF_INTERVAL (REF_INTERVAL),
        .T_RP         (T_RP),
        .T_RFC        (T_RFC),
        .REF_MAX      (REF_MAX)
    ) dut (
        .sclk         (sclk),
        .sresetn      (sresetn),
        .iGen_Req     (gen_req),
        .iGen_Cmd     (gen_cmd),
        .iGen_Bank    (gen_bank),
        .iGen_Addr    (gen_addr),
        .iGen_Idle    (gen_idle),
        .oGen_Gnt     (gen_gnt),
        .oCmd         (cmd),
        .oBank        (bank),
        .oAddr        (addr),
        .oRefBusy     (ref_busy),
        .oBanksClosed (banks_closed),
        .oRefErr      (ref_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge sclk);
        @(negedge sclk);
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd"},    32'(cmd), 32'(C_NOP));
        check({tag, "_bank"},   32'(bank), 32'd0);
        check({tag, "_addr"},   32'(addr), 32'd0);
        check({tag, "_gnt"},    32'(gen_gnt), 32'd0);
        check({tag, "_busy"},   32'(ref_busy), 32'd0);
        check({tag, "_closed"}, 32'(banks_closed), 32'd0);
        check({tag, "_err"},    32'(ref_err), 32'd0);
    endtask

    task automatic wait_gnt_fall(input int exp_cyc);
        int budget = 300;
        while (gen_gnt && budget > 0) begin
            step();
            budget--;
        end
        check("gnt_fall_cycle", 32'(cyc), 32'(exp_cyc));
        check("gnt_fall_busy", 32'(ref_busy), 32'd1);
    endtask

    // Next cycle must show PRE_ALL; then exact T_RP / T_RFC spacing, NOP-only gaps, DONE pulse.
    task automatic refresh_seq(input int n_refs);
        int   refs  = 0;
        int   guard = 0;
        logic done  = 1'b0;
        step();
        check("pre_cmd",  32'(cmd), 32'(C_PRA));
        check("pre_addr", 32'(addr), 32'h400);
        check("pre_bank", 32'(bank), 32'd0);
        check("pre_gnt",  32'(gen_gnt), 32'd0);
        for (int i = 1; i < T_RP; i++) begin
            step();
            check("trp_nop", 32'(cmd), 32'(C_NOP));
        end
        step();
        check("ref_first", 32'(cmd), 32'(C_REF));
        refs = 1;
        while (!done && guard < 20) begin
            guard++;
            for (int i = 1; i < T_RFC; i++) begin
                step();
                check("trfc_nop", 32'(cmd), 32'(C_NOP));
                check("trfc_closed", 32'(banks_closed), 32'd0);
            end
            step();
            if (cmd == C_REF) begin
                refs++;
            end else begin
                done = 1'b1;
            end
        end
        check("done_closed", 32'(banks_closed), 32'd1);
        check("done_cmd",    32'(cmd), 32'(C_NOP));
        check("done_gnt",    32'(gen_gnt), 32'd0);
        check("ref_count",   32'(refs), 32'(n_refs));
        step();
        check("regrant_gnt",    32'(gen_gnt), 32'd1);
        check("regrant_closed", 32'(banks_closed), 32'd0);
        check("regrant_busy",   32'(ref_busy), 32'd0);
    endtask

    task automatic drive_gen(input logic req, input logic [3:0] c, input logic [1:0] b,
                             input logic [10:0] a);
        gen_req  = req;
        gen_cmd  = c;
        gen_bank = b;
        gen_addr = a;
    endtask

    initial begin
        sresetn  = 1'b0;
        gen_idle = 1'b1;
        drive_gen(1'b0, C_NOP, 2'd0, 11'd0);
        for (int i = 0; i < 5; i++) step();
        check_reset_outputs("rst");

        // Release between edges; grant must appear after the first edge.
        sresetn = 1'b1;
        cyc     = 0;
        step();
        check("rel_gnt", 32'(gen_gnt), 32'd1);
        check("rel_busy", 32'(ref_busy), 32'd0);

        drive_gen(1'b1, C_ACT, 2'd2, 11'h155);
        step();
        check("pt_act_cmd",  32'(cmd), 32'(C_ACT));
        check("pt_act_bank", 32'(bank), 32'd2);
        check("pt_act_addr", 32'(addr), 32'h155);
        drive_gen(1'b1, C_RD, 2'd1, 11'h2AA);
        step();
        check("pt_rd_cmd",  32'(cmd), 32'(C_RD));
        check("pt_rd_bank", 32'(bank), 32'd1);
        check("pt_rd_addr", 32'(addr), 32'h2AA);
        drive_gen(1'b0, C_NOP, 2'd0, 11'd0);
        step();
        check("pt_idle_cmd", 32'(cmd), 32'(C_NOP));

        // First tick during cycle 20 -> owed=1 at 20 -> HOLD at 21 -> PRE at 22.
        wait_gnt_fall(21);
        refresh_seq(1);

        // Generator busy: stay in HOLD emitting NOP only.
        gen_idle = 1'b0;
        wait_gnt_fall(41);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_nop", 32'(cmd), 32'(C_NOP));
            check("hold_gnt", 32'(gen_gnt), 32'd0);
        end
        gen_idle = 1'b1;
        // REF at 55; the tick at 60 lands inside tRFC so a second REF follows at 62.
        refresh_seq(2);

        // Generator requesting continuously.
        drive_gen(1'b1, C_ACT, 2'd3, 11'h0AB);
`ifdef SDRAM_REF_POSTPONE_EN
        // owed reaches 7 at 200; ticks at 220/240/260 extend the drain to 10 REFs.
        wait_gnt_fall(201);
        check("last_idle_cmd", 32'(cmd), 32'(C_ACT));
        refresh_seq(10);
`else
        wait_gnt_fall(81);
        check("last_idle_cmd",  32'(cmd), 32'(C_ACT));
        check("last_idle_bank", 32'(bank), 32'd3);
        refresh_seq(1);
`endif
        drive_gen(1'b0, C_NOP, 2'd0, 11'd0);

        // Overflow: generator never idle, owed saturates at 8 (cycle 160); 9th tick at 180.
        sresetn = 1'b0;
        step();
        step();
        check_reset_outputs("rst2");
        gen_idle = 1'b0;
        sresetn  = 1'b1;
        cyc      = 0;
        while (cyc < 179) step();
        check("ovf_err_before", 32'(ref_err), 32'd0);
        check("ovf_gnt_hold",   32'(gen_gnt), 32'd0);
        step();
        check("ovf_err_set", 32'(ref_err), 32'd1);
        while (cyc < 210) step();
        check("ovf_err_sticky", 32'(ref_err), 32'd1);
        check("ovf_cmd_nop",    32'(cmd), 32'(C_NOP));

        // Reset in the middle of a held refresh clears everything.
        sresetn = 1'b0;
        step();
        check_reset_outputs("rst3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
